// File: rtl/ieee_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor (denormals flushed to zero,
// round to nearest even). One FSM state per clock: IDLE-UNPACK-ALIGN-ADD-NORM-ROUND-DONE.
module ieee_addsub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] number1,
    input  logic [31:0] number2,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        ROUND  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t             r_state, w_next;
    logic [31:0]        r_a, r_b;
    logic               r_op;
    logic               r_sa, r_sb;
    logic [7:0]         r_ea, r_eb;
    logic [23:0]        r_ma, r_mb;
    logic               r_special;
    logic [31:0]        r_spec_res;
    logic               r_sign, r_sub;
    logic signed [9:0]  r_exp;
    logic [26:0]        r_mx, r_my;
    logic [27:0]        r_sum;
    logic [26:0]        r_mn;
    logic               r_zero;
    logic [31:0]        r_result;
    logic               r_in_ready, r_out_valid;

    logic [7:0]         w_ea, w_eb;
    logic               w_sb_eff, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic [23:0]        w_ma, w_mb;
    logic               w_special;
    logic [31:0]        w_spec_res;
    logic               w_a_big, w_s_big;
    logic [7:0]         w_e_big, w_e_small, w_diff;
    logic [23:0]        w_m_big, w_m_small;
    logic [53:0]        w_wide;
    logic [26:0]        w_my;
    logic [27:0]        w_sum;
    logic [4:0]         w_lz;
    logic [26:0]        w_shl, w_mn;
    logic signed [9:0]  w_en, w_er;
    logic               w_nzero, w_up;
    logic [24:0]        w_rm;
    logic [22:0]        w_frac;
    logic [31:0]        w_res;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            n = v[i] ? 5'(26 - i) : n;
        end
        return n;
    endfunction

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) w_next = UNPACK;
                else                        w_next = IDLE;
            end
            UNPACK: w_next = ALIGN;
            ALIGN:  w_next = ADD;
            ADD:    w_next = NORM;
            NORM:   w_next = ROUND;
            ROUND:  w_next = DONE;
            DONE: begin
                if (out_ready) w_next = IDLE;
                else           w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Unpack: field split, denormal flush, effective sign of B and special-value resolution
    always_comb begin
        w_ea     = r_a[30:23];
        w_eb     = r_b[30:23];
        w_sb_eff = r_b[31] ^ r_op;
        w_nan_a  = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
        w_nan_b  = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
        w_inf_a  = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
        w_inf_b  = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
        w_ma     = (w_ea == 8'd0) ? 24'd0 : {1'b1, r_a[22:0]};
        w_mb     = (w_eb == 8'd0) ? 24'd0 : {1'b1, r_b[22:0]};
        w_special  = 1'b1;
        w_spec_res = 32'h7FC0_0000;
        if (w_nan_a || w_nan_b) begin
            w_spec_res = 32'h7FC0_0000;
        end else if (w_inf_a && w_inf_b) begin
            if (r_a[31] != w_sb_eff) w_spec_res = 32'h7FC0_0000;
            else                     w_spec_res = {r_a[31], 8'hFF, 23'd0};
        end else if (w_inf_a) begin
            w_spec_res = {r_a[31], 8'hFF, 23'd0};
        end else if (w_inf_b) begin
            w_spec_res = {w_sb_eff, 8'hFF, 23'd0};
        end else begin
            w_special  = 1'b0;
            w_spec_res = 32'd0;
        end
    end

    // Align: larger magnitude first; smaller shifted right with G/R/S kept
    always_comb begin
        w_a_big = {r_ea, r_ma} >= {r_eb, r_mb};
        if (w_a_big) begin
            w_e_big = r_ea; w_m_big = r_ma; w_s_big = r_sa;
            w_e_small = r_eb; w_m_small = r_mb;
        end else begin
            w_e_big = r_eb; w_m_big = r_mb; w_s_big = r_sb;
            w_e_small = r_ea; w_m_small = r_ma;
        end
        w_diff = w_e_big - w_e_small;
        w_wide = {w_m_small, 30'd0} >> w_diff;
        if (w_diff > 8'd25) begin
            w_my = {26'd0, |w_m_small};
        end else begin
            w_my = w_wide[53:27] | {26'd0, |w_wide[26:0]};
        end
    end

    assign w_sum = r_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});

    // Normalize: carry shifts right once, otherwise single-cycle left shift by leading zeros
    always_comb begin
        w_lz  = lzc27(r_sum[26:0]);
        w_shl = r_sum[26:0] << w_lz;
        if (r_sum[27]) begin
            w_mn = {r_sum[27:2], |r_sum[1:0]};
            w_en = r_exp + 10'sd1;
        end else begin
            w_mn = w_shl;
            w_en = r_exp - $signed({5'd0, w_lz});
        end
        w_nzero = (r_sum == 28'd0) || (w_en <= 10'sd0);
    end

    // Round to nearest even and pack, with overflow to infinity
    always_comb begin
        w_up = r_mn[2] & (r_mn[1] | r_mn[0] | r_mn[3]);
        w_rm = {1'b0, r_mn[26:3]} + {24'd0, w_up};
        if (w_rm[24]) begin
            w_er   = r_exp + 10'sd1;
            w_frac = w_rm[23:1];
        end else begin
            w_er   = r_exp;
            w_frac = w_rm[22:0];
        end
        if (r_special) begin
            w_res = r_spec_res;
        end else if (r_zero) begin
            w_res = {r_sign, 31'd0};
        end else if (w_er >= 10'sd255) begin
            w_res = {r_sign, 8'hFF, 23'd0};
        end else begin
            w_res = {r_sign, w_er[7:0], w_frac};
        end
    end

    // Handshake outputs, registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == IDLE);
            r_out_valid <= (w_next == DONE);
        end
    end

    // Datapath pipeline registers, each written only in its own state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= 32'd0; r_b <= 32'd0; r_op <= 1'b0;
            r_sa <= 1'b0; r_sb <= 1'b0; r_ea <= 8'd0; r_eb <= 8'd0;
            r_ma <= 24'd0; r_mb <= 24'd0;
            r_special <= 1'b0; r_spec_res <= 32'd0;
            r_sign <= 1'b0; r_sub <= 1'b0; r_exp <= 10'sd0;
            r_mx <= 27'd0; r_my <= 27'd0; r_sum <= 28'd0;
            r_mn <= 27'd0; r_zero <= 1'b0; r_result <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a  <= number1;
                        r_b  <= number2;
                        r_op <= op;
                    end
                end
                UNPACK: begin
                    r_sa <= r_a[31];  r_sb <= w_sb_eff;
                    r_ea <= w_ea;     r_eb <= w_eb;
                    r_ma <= w_ma;     r_mb <= w_mb;
                    r_special  <= w_special;
                    r_spec_res <= w_spec_res;
                end
                ALIGN: begin
                    r_mx   <= {w_m_big, 3'b000};
                    r_my   <= w_my;
                    r_exp  <= $signed({2'b00, w_e_big});
                    r_sign <= w_s_big;
                    r_sub  <= r_sa ^ r_sb;
                end
                ADD: begin
                    r_sum <= w_sum;
                    // exact cancellation always yields +0
                    if (r_sub && (w_sum == 28'd0)) r_sign <= 1'b0;
                end
                NORM: begin
                    r_mn   <= w_mn;
                    r_exp  <= w_en;
                    r_zero <= w_nzero;
                end
                ROUND: r_result <= w_res;
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee_addsub_seq.sv
// Scoreboard bench for ieee_addsub_seq: directed vectors plus randomized operands checked
// against an exact wide-integer reference of flush-to-zero, round-to-nearest-even add/sub.
module tb_ieee_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] number1 = 32'd0;
    logic [31:0] number2 = 32'd0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic        prev_valid = 1'b0;

    ieee_addsub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .number1   (number1),
        .number2   (number2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    // Exact reference: operands as integers scaled to a common exponent, rounded once.
    function automatic logic [31:0] ref_addsub(input logic [31:0] a, input logic [31:0] b, input logic o);
        logic         sa, sb, s;
        int           ea, eb, emin, p, e, sh;
        logic [299:0] ma, mb, t, rem, half, tmp;
        logic [24:0]  m;
        sa = a[31];
        sb = b[31] ^ o;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 23'd0) || (eb == 255 && b[22:0] != 23'd0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
        if (ea == 255) return {sa, 8'hFF, 23'd0};
        if (eb == 255) return {sb, 8'hFF, 23'd0};
        if (ea == 0 && eb == 0) return (sa == sb) ? {sa, 31'd0} : 32'd0;
        ma = '0;
        mb = '0;
        if (ea != 0) ma[23:0] = {1'b1, a[22:0]};
        if (eb != 0) mb[23:0] = {1'b1, b[22:0]};
        if (ea == 0)      emin = eb;
        else if (eb == 0) emin = ea;
        else              emin = (ea < eb) ? ea : eb;
        if (ea != 0) ma = ma << (ea - emin);
        if (eb != 0) mb = mb << (eb - emin);
        if (sa == sb)      begin t = ma + mb; s = sa; end
        else if (ma >= mb) begin t = ma - mb; s = sa; end
        else               begin t = mb - ma; s = sb; end
        if (t == '0) return 32'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (t[i]) p = i;
        e = p + emin - 23;
        if (e <= 0) return {s, 31'd0};
        if (p <= 23) begin
            tmp = t << (23 - p);
            m = tmp[24:0];
        end else begin
            sh = p - 23;
            tmp = t >> sh;
            m = tmp[24:0];
            half = 300'd1 << (sh - 1);
            rem = t & ((300'd1 << sh) - 300'd1);
            if (rem > half || (rem == half && m[0])) m = m + 25'd1;
            if (m[24]) begin
                m = m >> 1;
                e++;
            end
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] gen_special();
        case ($urandom_range(0, 6))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'hFF800000;
            4: return 32'h7FC00001;
            5: return 32'h00012345;
            default: return 32'h7F7FFFFF;
        endcase
    endfunction

    function automatic logic [31:0] gen_b(input logic [31:0] a);
        logic [31:0] r;
        logic [7:0]  e;
        int          mode;
        mode = $urandom_range(0, 9);
        r = $urandom;
        if (mode >= 4 && mode <= 5) begin
            r[30:23] = a[30:23];
        end else if (mode >= 6 && mode <= 7) begin
            e = a[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
            r[30:23] = e;
        end else if (mode == 8) begin
            r = gen_special();
        end else if (mode == 9) begin
            r = {1'($urandom_range(0, 1)), a[30:0]};
        end
        return r;
    endfunction

    // Monitor: pop and compare each time a new result is presented
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got %08h, required no output", result);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", result, mon_exp);
            end
        end
        prev_valid = out_valid;
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                         input logic [31:0] expv, input int stall);
        int t;
        int edges;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        number1 = a;
        number2 = b;
        op = o;
        in_valid = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(expv);
        n_vec++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        number1 = $urandom;
        number2 = $urandom;
        op = 1'($urandom_range(0, 1));
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency", 32'(edges), 32'd6);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            number1 = $urandom;
            number2 = $urandom;
            @(posedge clk);
            #1;
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_result", result, expv);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("after_done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("after_done_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_done_result_held", result, expv);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        o;
        logic        saw;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'h40ADF06F, 32'h40ADEAB3, 1'b1, 32'h3A378000, 10);
        do_op(32'hC1CED2F2, 32'hC1CF49BA, 1'b1, 32'h3D6D9000, 0);
        do_op(32'hC0000000, 32'h41100000, 1'b0, 32'h40E00000, 1);
        do_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 0);
        do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2);
        do_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 0);
        do_op(32'h4B000000, 32'h3F000000, 1'b0, 32'h4B000000, 0);
        do_op(32'h4B000000, 32'h3F400000, 1'b0, 32'h4B000001, 0);
        do_op(32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 0);
        do_op(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 0);
        do_op(32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 0);

        // reset while the operation is in ADD
        @(negedge clk);
        number1 = 32'h40400000;
        number2 = 32'h3F800000;
        op = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("midrst_no_valid", {31'd0, saw}, 32'd0);
        rst_n = 1'b1;
        do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 0);

        for (int k = 0; k < 300; k++) begin
            a = ($urandom_range(0, 9) == 0) ? gen_special() : $urandom;
            b = gen_b(a);
            o = 1'($urandom_range(0, 1));
            do_op(a, b, o, ref_addsub(a, b, o), $urandom_range(0, 3));
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ieee_addsub_seq.md
IEEE_ADDSUB_SEQ -- requirements
Module: ieee_addsub_seq

Interface
REQ-001 The block SHALL use one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
REQ-002 Port list, SHALL be exactly:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- number1  in  32  IEEE-754 single operand A.
- number2  in  32  IEEE-754 single operand B.
- op  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  32  IEEE-754 single result.

Function
REQ-003 The FSM SHALL have states IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE, advancing one state per clk except as stated below.
REQ-004 in_ready SHALL be 1 only in IDLE; an accept occurs on a clk edge with in_valid=1 and in_ready=1, capturing number1, number2 and op, then IDLE->UNPACK.
REQ-005 Operand or op changes after accept SHALL NOT affect the in-flight result.
REQ-006 UNPACK:
- split sign, exponent and mantissa; add the hidden 1 for exponent!=0.
- treat exponent==0 operands as signed zero (denormal flush).
- for op=1, invert the sign of B.
REQ-007 ALIGN:
- swap operands so the larger magnitude is the first operand.
- right-shift the smaller mantissa by the exponent difference, preserving guard, round and sticky bits.
- a difference >25 leaves only sticky.
REQ-008 ADD: add mantissas (equal effective signs) or subtract smaller from larger (unequal); result sign = sign of the larger magnitude.
REQ-009 NORM:
- on carry-out, right-shift 1 and exponent+1;
- otherwise left-shift by the leading-zero count (single cycle) and decrement the exponent.
- exponent underflow (<=0) SHALL produce signed zero.
REQ-010 ROUND:
- round to nearest, ties to even, using guard/round/sticky.
- mantissa overflow from rounding increments the exponent.
- exponent >=255 SHALL produce signed infinity.
REQ-011 Exact cancellation (equal magnitudes, opposite effective signs) SHALL give +0 (0x00000000).
REQ-012 Special cases SHALL be resolved in UNPACK and carried unchanged through the remaining states:
- any NaN input -> 0x7FC00000.
- inf + (-inf) effective -> 0x7FC00000.
- inf with finite -> that inf.
- inf with inf of the same effective sign -> that inf.
REQ-013 Latency SHALL be exactly 6 clk edges from the accept edge to the edge on which out_valid rises.
REQ-014 In DONE, out_valid SHALL be 1, and result SHALL be held stable while out_ready=0.
REQ-015 A clk edge in DONE with out_ready=1 SHALL return the FSM to IDLE; in_ready=1 on the following cycle, and no back-to-back accept occurs in the same edge.
REQ-016 result SHALL keep its last value after leaving DONE until the next result is loaded; out_valid=0 outside DONE.
REQ-017 The datapath width rules SHALL be:
- aligned mantissas 27 bits (1 hidden + 23 + G, R, S);
- sum 28 bits;
- exponent arithmetic 10-bit signed.

Reset
REQ-018 While rst_n=0, the block SHALL force state=IDLE, in_ready=1, out_valid=0, result=0x00000000 and internal registers=0, regardless of clk.
REQ-019 Reset asserted mid-operation SHALL abort the operation with no out_valid pulse; the first accept after release starts a fresh operation.

Verification
REQ-020 A=0x40ADF06F, B=0x40ADEAB3, op=1 -> result=0x3A378000, out_valid exactly 6 edges after accept.
REQ-021 A=0xC1CED2F2, B=0xC1CF49BA, op=1 -> 0x3D6D9000; A=0xC0000000, B=0x41100000, op=0 -> 0x40E00000 (-2+9=7).
REQ-022 Specials:
- A=0x7F800000, B=0x7F800000, op=1 -> 0x7FC00000.
- A=0x7F7FFFFF, B=0x7F7FFFFF, op=0 -> 0x7F800000.
- A=0x3F800000, B=0x3F800000, op=1 -> 0x00000000.
REQ-023 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and out_valid stable, in_ready=0; operands changed meanwhile are ignored; out_ready=1 -> IDLE next edge.
REQ-024 Rounding tie: A=0x4B000000 (2^23), B=0x3F000000 (0.5), op=0 -> 0x4B000000 (tie to even); B=0x3F400000 (0.75) -> 0x4B000001.
REQ-025 Assert rst_n=0 during ADD -> out_valid never rises, in_ready=1 immediately; release and issue 1.0+1.0 -> 0x40000000 after 6 edges.
